// File: rtl/wb_arbiter.sv
// Three-requester round-robin arbiter feeding a single registered register-file write port.
// A halt request drains in-flight traffic and then parks the arbiter until reset.
module wb_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          l_valid,
  input  logic [AW-1:0] l_rt,
  input  logic [DW-1:0] l_data,
  input  logic          s_valid,
  input  logic [AW-1:0] s_rt,
  input  logic [DW-1:0] s_data,
  input  logic          v_valid,
  input  logic [AW-1:0] v_rt,
  input  logic [DW-1:0] v_data,
  output logic          l_ready,
  output logic          s_ready,
  output logic          v_ready,
  input  logic          flush,
  input  logic          halt_req,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          halted
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [2:0]    elig;
  logic [2:0]    gnt;
  logic [1:0]    gidx;
  logic [1:0]    idx;
  logic          found;
  logic [AW-1:0] sel_rt;
  logic [DW-1:0] sel_data;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic pick(input logic [2:0] e, input logic [1:0] i);
    case (i)
      2'd0:    pick = e[0];
      2'd1:    pick = e[1];
      default: pick = e[2];
    endcase
  endfunction

  // flush only blocks the younger scalar/vector results; load returns still land
  always_comb begin
    elig = '0;
    if (!reset && state != HALTED)
      elig = {v_valid & ~flush, s_valid & ~flush, l_valid};
    found = 1'b0;
    gidx  = ptr;
    idx   = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && pick(elig, idx)) begin
        found = 1'b1;
        gidx  = idx;
      end
      idx = inc3(idx);
    end
    gnt = '0;
    if (found) begin
      case (gidx)
        2'd0:    gnt = 3'b001;
        2'd1:    gnt = 3'b010;
        default: gnt = 3'b100;
      endcase
    end
  end

  assign l_ready = gnt[0];
  assign s_ready = gnt[1];
  assign v_ready = gnt[2];

  always_comb begin
    case (gidx)
      2'd0:    begin sel_rt = l_rt; sel_data = l_data; end
      2'd1:    begin sel_rt = s_rt; sel_data = s_data; end
      default: begin sel_rt = v_rt; sel_data = v_data; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      ptr     <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      halted  <= 1'b0;
    end else begin
      wr_en <= found;
      if (found) begin
        wr_addr <= sel_rt;
        wr_data <= sel_data;
        ptr     <= inc3(gidx);
      end
      case (state)
        RUN:
          if (halt_req) state <= DRAIN;
        DRAIN:
          // drained once nothing is requesting and the last write has retired
          if (!l_valid && !s_valid && !v_valid && !wr_en) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule
